// File: rtl/ariane_pkg.sv
// ariane_pkg: FENCE.T control-word field positions shared by decode, CSR/commit and fence sequencing.
// Revision: 1.0
`default_nettype none

package ariane_pkg;

  localparam int FENCE_T_W       = 20;
  localparam int FENCE_T_D_BIT   = 0;
  localparam int FENCE_T_I_BIT   = 1;
  localparam int FENCE_T_TLB_BIT = 2;
  localparam int FENCE_T_BP_BIT  = 3;
  localparam int FENCE_T_PAD_LSB = 8;
  localparam int FENCE_T_PAD_W   = 12;

endpackage

`default_nettype wire

// File: rtl/fence_pad_counter.sv
// fence_pad_counter: saturating cycle counter with clear/enable and a look-ahead compare against a pad.
// Revision: 1.0
`default_nettype none

module fence_pad_counter #(
  parameter int W = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] pad,
  output logic         reached
);

  logic [W-1:0] cnt;
  logic [W-1:0] base;
  logic [W-1:0] next_cnt;

  // While clear is held the count is treated as zero, so a start in that cycle counts from 0.
  assign base     = clear ? '0 : cnt;
  assign next_cnt = (&base) ? base : base + 1'b1;
  assign reached  = (next_cnt >= pad);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= next_cnt;
    end else if (clear) begin
      cnt <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fence_sequencer.sv
// fence_sequencer: orders D$/I$/TLB/BP flushes, FENCE.T padding and the final pipeline flush for fences.
// Revision: 1.0
`default_nettype none

module fence_sequencer
  import ariane_pkg::*;
#(
  parameter int PAD_W = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 fence_i_i,
  input  logic                 fence_d_i,
  input  logic                 sfence_vma_i,
  input  logic [FENCE_T_W-1:0] fence_t_i,
  input  logic                 flush_commit_i,
  input  logic                 flush_dcache_ack_i,
  output logic                 flush_dcache_o,
  output logic                 flush_icache_o,
  output logic                 flush_tlb_o,
  output logic                 flush_bp_o,
  output logic                 flush_pipeline_o,
  output logic                 set_pc_commit_o,
  output logic                 halt_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FLUSH_D    = 3'd1,
    FLUSH_REST = 3'd2,
    PAD        = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t           state;
  logic             need_d, need_i, need_tlb, need_bp;
  logic [PAD_W-1:0] pad_q;

  logic             req, req_d, req_i, req_tlb, req_bp;
  logic [PAD_W-1:0] req_pad;
  logic             idle, rest_q, rest_req, reached;
  logic [PAD_W-1:0] cmp_pad;

  // Priority decode: FENCE.T > FENCE.I > FENCE > SFENCE.VMA > AMO flush.
  always_comb begin
    req     = (|fence_t_i) | fence_i_i | fence_d_i | sfence_vma_i | flush_commit_i;
    req_d   = 1'b0;
    req_i   = 1'b0;
    req_tlb = 1'b0;
    req_bp  = 1'b0;
    req_pad = '0;
    if (|fence_t_i) begin
      req_d   = fence_t_i[FENCE_T_D_BIT];
      req_i   = fence_t_i[FENCE_T_I_BIT];
      req_tlb = fence_t_i[FENCE_T_TLB_BIT];
      req_bp  = fence_t_i[FENCE_T_BP_BIT];
      req_pad = fence_t_i[FENCE_T_PAD_LSB +: PAD_W];
    end else if (fence_i_i) begin
      req_d = 1'b1;
      req_i = 1'b1;
    end else if (fence_d_i) begin
      req_d = 1'b1;
    end else if (sfence_vma_i) begin
      req_tlb = 1'b1;
    end
  end

  assign idle     = (state == IDLE);
  assign rest_req = req_i | req_tlb | req_bp;
  assign rest_q   = need_i | need_tlb | need_bp;
  assign cmp_pad  = idle ? req_pad : pad_q;

  fence_pad_counter #(
    .W (PAD_W)
  ) u_pad_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear   (idle),
    .enable  (!idle || req),
    .pad     (cmp_pad),
    .reached (reached)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      need_d           <= 1'b0;
      need_i           <= 1'b0;
      need_tlb         <= 1'b0;
      need_bp          <= 1'b0;
      pad_q            <= '0;
      flush_dcache_o   <= 1'b0;
      flush_icache_o   <= 1'b0;
      flush_tlb_o      <= 1'b0;
      flush_bp_o       <= 1'b0;
      flush_pipeline_o <= 1'b0;
      set_pc_commit_o  <= 1'b0;
      halt_o           <= 1'b0;
    end else begin
      flush_icache_o   <= 1'b0;
      flush_tlb_o      <= 1'b0;
      flush_bp_o       <= 1'b0;
      flush_pipeline_o <= 1'b0;
      set_pc_commit_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            need_d   <= req_d;
            need_i   <= req_i;
            need_tlb <= req_tlb;
            need_bp  <= req_bp;
            pad_q    <= req_pad;
            halt_o   <= 1'b1;
            if (req_d) begin
              state          <= FLUSH_D;
              flush_dcache_o <= 1'b1;
            end else if (rest_req) begin
              state          <= FLUSH_REST;
              flush_icache_o <= req_i;
              flush_tlb_o    <= req_tlb;
              flush_bp_o     <= req_bp;
            end else if (reached) begin
              state            <= DONE;
              flush_pipeline_o <= 1'b1;
              set_pc_commit_o  <= 1'b1;
            end else begin
              state <= PAD;
            end
          end
        end
        FLUSH_D: begin
          if (flush_dcache_ack_i) begin
            flush_dcache_o <= 1'b0;
            if (rest_q) begin
              state          <= FLUSH_REST;
              flush_icache_o <= need_i;
              flush_tlb_o    <= need_tlb;
              flush_bp_o     <= need_bp;
            end else if (reached) begin
              state            <= DONE;
              flush_pipeline_o <= 1'b1;
              set_pc_commit_o  <= 1'b1;
            end else begin
              state <= PAD;
            end
          end
        end
        FLUSH_REST, PAD: begin
          if (reached) begin
            state            <= DONE;
            flush_pipeline_o <= 1'b1;
            set_pc_commit_o  <= 1'b1;
          end else begin
            state <= PAD;
          end
        end
        DONE: begin
          state  <= IDLE;
          halt_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          halt_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fence_sequencer.sv
// tb_fence_sequencer: directed fence scenarios checked cycle-by-cycle against a schedule model.
// Revision: 1.0
`default_nettype none

module tb_fence_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        fence_i_i = 1'b0;
  logic        fence_d_i = 1'b0;
  logic        sfence_vma_i = 1'b0;
  logic [19:0] fence_t_i = '0;
  logic        flush_commit_i = 1'b0;
  logic        flush_dcache_ack_i = 1'b0;
  logic        flush_dcache_o, flush_icache_o, flush_tlb_o, flush_bp_o;
  logic        flush_pipeline_o, set_pc_commit_o, halt_o;

  fence_sequencer #(.PAD_W(12)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .fence_i_i          (fence_i_i),
    .fence_d_i          (fence_d_i),
    .sfence_vma_i       (sfence_vma_i),
    .fence_t_i          (fence_t_i),
    .flush_commit_i     (flush_commit_i),
    .flush_dcache_ack_i (flush_dcache_ack_i),
    .flush_dcache_o     (flush_dcache_o),
    .flush_icache_o     (flush_icache_o),
    .flush_tlb_o        (flush_tlb_o),
    .flush_bp_o         (flush_bp_o),
    .flush_pipeline_o   (flush_pipeline_o),
    .set_pc_commit_o    (set_pc_commit_o),
    .halt_o             (halt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Schedule model: cycle offsets of every output relative to the accept cycle.
  bit m_active = 0;
  int m_start, m_k, m_rest, m_done;
  bit m_d, m_i, m_t, m_b;

  int seen_done, seen_ic, seen_tlb, seen_bp, d_cnt, h_cnt;

  task automatic cmp(input string name, input logic act, input logic exp, input int r);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s at rel cycle %0d: got %b, want %b", name, r, act, exp);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic plan(input bit fi, input bit fd, input bit sv, input logic [19:0] ft, input int k);
    int pad, t;
    m_d = 0; m_i = 0; m_t = 0; m_b = 0; pad = 0;
    if (ft != 0) begin
      m_d = ft[0]; m_i = ft[1]; m_t = ft[2]; m_b = ft[3];
      pad = int'(ft[19:8]);
    end else if (fi) begin
      m_d = 1; m_i = 1;
    end else if (fd) begin
      m_d = 1;
    end else if (sv) begin
      m_t = 1;
    end
    t = 0;
    if (m_d) t = k;
    m_rest = -1;
    if (m_i || m_t || m_b) begin
      t = t + 1;
      m_rest = t;
    end
    m_done = (t + 1 > pad) ? t + 1 : pad;
    m_k = k;
  endtask

  always @(negedge clk) begin
    int r;
    bit e_d, e_i, e_t, e_b, e_p, e_h;
    r = cyc - m_start;
    e_d = m_active && m_d && r >= 1 && r <= m_k;
    e_i = m_active && m_i && r == m_rest;
    e_t = m_active && m_t && r == m_rest;
    e_b = m_active && m_b && r == m_rest;
    e_p = m_active && r == m_done;
    e_h = m_active && r >= 1 && r <= m_done;
    cmp("flush_dcache", flush_dcache_o, e_d, r);
    cmp("flush_icache", flush_icache_o, e_i, r);
    cmp("flush_tlb", flush_tlb_o, e_t, r);
    cmp("flush_bp", flush_bp_o, e_b, r);
    cmp("flush_pipeline", flush_pipeline_o, e_p, r);
    cmp("set_pc_commit", set_pc_commit_o, e_p, r);
    cmp("halt", halt_o, e_h, r);
    if (m_active) begin
      if (flush_pipeline_o === 1'b1 && seen_done < 0) seen_done = r;
      if (flush_icache_o === 1'b1 && seen_ic < 0) seen_ic = r;
      if (flush_tlb_o === 1'b1 && seen_tlb < 0) seen_tlb = r;
      if (flush_bp_o === 1'b1 && seen_bp < 0) seen_bp = r;
      if (flush_dcache_o === 1'b1) d_cnt++;
      if (halt_o === 1'b1) h_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fence_i_i = 0; fence_d_i = 0; sfence_vma_i = 0; fence_t_i = '0;
    flush_commit_i = 0; flush_dcache_ack_i = 0;
  endtask

  task automatic start_model(input bit fi, input bit fd, input bit sv, input logic [19:0] ft, input int k);
    plan(fi, fd, sv, ft, k);
    m_start = cyc; m_active = 1;
    seen_done = -1; seen_ic = -1; seen_tlb = -1; seen_bp = -1; d_cnt = 0; h_cnt = 0;
  endtask

  // Accept at rel cycle 0, ack at rel cycle k (0 = none), stray FENCE at late_fd, optional stray acks before.
  task automatic run(input bit fi, input bit fd, input bit sv, input logic [19:0] ft, input bit fc,
                     input int k, input int late_fd, input bit spur);
    if (spur) begin
      flush_dcache_ack_i = 1;
      step();
    end
    start_model(fi, fd, sv, ft, k);
    for (int r = 0; r <= m_done; r++) begin
      fence_i_i          = (r == 0) && fi;
      fence_d_i          = ((r == 0) && fd) || (r == late_fd);
      sfence_vma_i       = (r == 0) && sv;
      fence_t_i          = (r == 0) ? ft : 20'h0;
      flush_commit_i     = (r == 0) && fc;
      flush_dcache_ack_i = (k > 0 && r == k) || (spur && r == 0);
      step();
    end
    clear_inputs();
  endtask

  initial begin
    #1 rst_ni = 0;
    repeat (3) step();
    rst_ni = 1;
    step();

    run(1, 0, 0, 20'h0, 0, 5, -1, 0);
    lit("fence_i done cycle", seen_done, 7);
    lit("fence_i icache cycle", seen_ic, 6);
    lit("fence_i dcache cycles", d_cnt, 5);
    lit("fence_i halt cycles", h_cnt, 7);

    run(0, 0, 1, 20'h0, 0, 0, -1, 0);
    lit("sfence tlb cycle", seen_tlb, 1);
    lit("sfence done cycle", seen_done, 2);
    lit("sfence dcache cycles", d_cnt, 0);

    run(0, 0, 0, 20'h0140F, 0, 3, -1, 0);
    lit("fence_t rest cycle", seen_bp, 4);
    lit("fence_t done cycle", seen_done, 20);
    lit("fence_t halt cycles", h_cnt, 20);

    run(1, 0, 0, 20'h0, 1, 5, 3, 0);
    lit("priority done cycle", seen_done, 7);
    lit("priority icache cycle", seen_ic, 6);

    run(0, 0, 0, 20'h0, 1, 0, -1, 0);
    lit("amo done cycle", seen_done, 1);
    lit("amo halt cycles", h_cnt, 1);

    // Reset in the middle of a FENCE that is waiting for its ack.
    step();
    fence_d_i = 1;
    start_model(0, 1, 0, 20'h0, 1000);
    step(); fence_d_i = 0;
    step(); step();
    #2 rst_ni = 0; m_active = 0;
    #1;
    lit("async reset dcache", int'(flush_dcache_o), 0);
    lit("async reset halt", int'(halt_o), 0);
    step(); flush_dcache_ack_i = 1;
    step(); flush_dcache_ack_i = 0;
    step(); rst_ni = 1;
    step(); flush_dcache_ack_i = 1;
    step(); flush_dcache_ack_i = 0;
    step();
    run(0, 1, 0, 20'h0, 0, 2, -1, 0);
    lit("post-reset fence done", seen_done, 3);
    lit("post-reset fence dcache cycles", d_cnt, 2);

    run(0, 1, 0, 20'h0, 0, 4, -1, 1);
    lit("spurious-ack fence done", seen_done, 5);
    lit("spurious-ack dcache cycles", d_cnt, 4);

    run(0, 0, 0, 20'hFFF00, 0, 0, -1, 0);
    lit("saturation done cycle", seen_done, 4095);

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
